outfifo_arbiter: RTL
====================

# outfifo_arbiter

Egress-side counterpart of the input FIFO arbiter: it drains completed packets from the NUM_THREADS per-thread output FIFOs onto the single shared output stream, one whole packet at a time, granting threads in round-robin order. When a packet's last word has left, it pulses `fifo_done` for that thread, which releases the thread's busy state on the ingress side. It sits between the per-thread CPU/output FIFOs and the downstream output port.

## Interface
Parameters:
- NUM_THREADS, 8, number of thread FIFOs (power of two).
- THREAD_BITS, 3, log2(NUM_THREADS); width of thread ids.
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, 8, control byte width carried with each word.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- thread_pkt_ready  in  NUM_THREADS  bit i high: thread i holds a complete packet to send.
- thread_empty  in  NUM_THREADS  bit i high: thread i FIFO empty (FWFT FIFO, head word valid when low).
- thread_data  in  NUM_THREADS*DATA_WIDTH  head words, thread i at [i*DATA_WIDTH +: DATA_WIDTH].
- thread_ctrl  in  NUM_THREADS*CTRL_WIDTH  head ctrl bytes, same packing.
- thread_last  in  NUM_THREADS  head word of thread i is last word of its packet.
- thread_rd_en  out  NUM_THREADS  pop head word of thread i; one-hot or zero.
- out_rdy  in  1  downstream can accept a word this cycle.
- out_wr  out  1  out_data/out_ctrl valid, registered.
- out_data  out  DATA_WIDTH  output word, registered.
- out_ctrl  out  CTRL_WIDTH  output ctrl, registered.
- fifo_done  out  NUM_THREADS  one-cycle pulse on bit of thread whose packet finished.
- active_thread  out  THREAD_BITS  currently granted thread.
- busy  out  1  high in SEND and DONE.
- pkt_count  out  32  packets completed since reset, wraps at 2^32.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: if any thread_pkt_ready bit set, grant first ready thread searching from rr_ptr+1 upward with wrap; latch into active_thread; go SEND. No ready bit: stay.
- SEND: thread_rd_en[g] = out_rdy && !thread_empty[g] (combinational, g = active_thread). On a pop, next edge registers out_data/out_ctrl from thread g and sets out_wr=1; otherwise out_wr=0 next cycle. Pop with thread_last[g]=1 -> DONE.
- DONE: fifo_done[g]=1 for exactly this cycle; rr_ptr <= g; pkt_count increments; go IDLE.
- Threads clear their thread_pkt_ready synchronously on fifo_done, so a thread is never re-granted for the same packet.
- thread_pkt_ready changes during SEND/DONE are ignored until next IDLE.
- Only granted thread ever sees thread_rd_en; other inputs ignored.

## Timing
- Reset values: state IDLE, rr_ptr = NUM_THREADS-1 (thread 0 wins first), active_thread 0, thread_rd_en 0, out_wr 0, out_data 0, out_ctrl 0, fifo_done 0, busy 0, pkt_count 0.
- Grant latency: ready seen in IDLE at cycle t -> SEND at t+1 -> first pop earliest t+1 -> out_wr at t+2.
- Throughput: one word per cycle while out_rdy=1 and FIFO non-empty; out_wr follows the pop by exactly one cycle.
- Per-packet overhead: 2 idle cycles (DONE + IDLE) between back-to-back packets.
- out_rdy low or thread FIFO empty mid-packet: no pop, out_wr=0, stay in SEND indefinitely; no timeout.
- Single-word packet: pop with last in first SEND cycle -> DONE next cycle.
- Reset mid-packet: abandon immediately, no fifo_done, all outputs to reset values next cycle.
- pkt_count wraps 0xFFFFFFFF -> 0.

## Test plan
- Reset: assert reset 2 cycles mid-SEND -> next cycle out_wr=0, fifo_done=0, busy=0, pkt_count=0, no further pops.
- Single packet: thread 3 ready with 4 words (last on 4th), out_rdy=1 -> out_wr high 4 consecutive cycles, data in order, fifo_done=8'b00001000 one cycle after the last pop, pkt_count=1.
- Round-robin: all 8 threads ready, 1-word packets -> grant order 0,1,...,7; then thread 2 re-ready only -> granted next.
- Backpressure: out_rdy toggled 1,0,0,1 during 3-word packet -> pops only on out_rdy=1 cycles, out_wr gaps match, word order intact.
- Underflow stall: thread 5 empty for 3 cycles mid-packet -> no pops, out_wr=0, state stays SEND, resumes on refill.
- Counter wrap: preload/force pkt_count=0xFFFFFFFF, complete one packet -> pkt_count=0.

Source files
------------

// File: rtl/outfifo_arbiter.sv
// outfifo_arbiter: drains whole packets from per-thread output FIFOs onto the
// single shared output stream. Threads are granted in round-robin order. When a
// packet's last word has left, fifo_done pulses for one cycle for that thread.
//
// Ports:
//   clk, reset        - single clock, synchronous active-high reset
//   thread_pkt_ready  - per-thread "complete packet available"
//   thread_empty      - per-thread FWFT FIFO empty (head valid when low)
//   thread_data/ctrl  - per-thread head word / ctrl byte, thread i at slice i
//   thread_last       - per-thread head word is the packet's last word
//   thread_rd_en      - pop strobe to the granted thread (one-hot or zero)
//   out_rdy           - downstream accepts a word this cycle
//   out_wr/data/ctrl  - registered output word
//   fifo_done         - one-cycle pulse on the thread whose packet finished
//   active_thread     - currently granted thread
//   busy              - high while a packet is in flight (SEND or DONE)
//   pkt_count         - packets completed since reset, wraps at 2^32
module outfifo_arbiter #(
    parameter int unsigned NUM_THREADS    = 8,
    parameter int unsigned THREAD_BITS    = 3,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned CTRL_WIDTH     = 8,
    // Value pkt_count takes on reset; lets a counter start near its wrap point.
    parameter logic [31:0] PKT_COUNT_INIT = 32'h0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_THREADS-1:0]            thread_pkt_ready,
    input  logic [NUM_THREADS-1:0]            thread_empty,
    input  logic [NUM_THREADS*DATA_WIDTH-1:0] thread_data,
    input  logic [NUM_THREADS*CTRL_WIDTH-1:0] thread_ctrl,
    input  logic [NUM_THREADS-1:0]            thread_last,
    output logic [NUM_THREADS-1:0]            thread_rd_en,
    input  logic                              out_rdy,
    output logic                              out_wr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [CTRL_WIDTH-1:0]             out_ctrl,
    output logic [NUM_THREADS-1:0]            fifo_done,
    output logic [THREAD_BITS-1:0]            active_thread,
    output logic                              busy,
    output logic [31:0]                       pkt_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [THREAD_BITS-1:0]  rr_ptr;
    logic [THREAD_BITS-1:0]  grant_c;
    logic [THREAD_BITS-1:0]  idx_c;
    logic                    grant_vld_c;
    logic                    pop_c;
    logic                    head_empty_c;
    logic                    head_last_c;
    logic [DATA_WIDTH-1:0]   head_data_c;
    logic [CTRL_WIDTH-1:0]   head_ctrl_c;

    // Round-robin search: first ready thread starting at rr_ptr+1, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_c     = '0;
        idx_c       = '0;
        for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
            idx_c = rr_ptr + THREAD_BITS'(i);
            if (!grant_vld_c && thread_pkt_ready[idx_c]) begin
                grant_vld_c = 1'b1;
                grant_c     = idx_c;
            end
        end
    end

    // Head-of-FIFO view of the granted thread.
    always_comb begin
        head_empty_c = 1'b1;
        head_last_c  = 1'b0;
        head_data_c  = '0;
        head_ctrl_c  = '0;
        for (int unsigned i = 0; i < NUM_THREADS; i++) begin
            if (active_thread == THREAD_BITS'(i)) begin
                head_empty_c = thread_empty[i];
                head_last_c  = thread_last[i];
                head_data_c  = thread_data[i*DATA_WIDTH +: DATA_WIDTH];
                head_ctrl_c  = thread_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state and pop strobe; reset suppresses the pop so an
    // interrupted packet loses no further words.
    always_comb begin
        state_next   = state;
        pop_c        = 1'b0;
        thread_rd_en = '0;
        case (state)
            ST_IDLE: begin
                if (grant_vld_c) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                pop_c = out_rdy && !head_empty_c && !reset;
                if (pop_c) begin
                    thread_rd_en = NUM_THREADS'(1) << active_thread;
                    if (head_last_c) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath, grant bookkeeping and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr        <= THREAD_BITS'(NUM_THREADS - 1);
            active_thread <= '0;
            out_wr        <= 1'b0;
            out_data      <= '0;
            out_ctrl      <= '0;
            fifo_done     <= '0;
            busy          <= 1'b0;
            pkt_count     <= PKT_COUNT_INIT;
        end else begin
            out_wr <= pop_c;
            if (pop_c) begin
                out_data <= head_data_c;
                out_ctrl <= head_ctrl_c;
            end
            // Pulse lands in the DONE cycle, one cycle after the last pop.
            if (pop_c && head_last_c) begin
                fifo_done <= NUM_THREADS'(1) << active_thread;
            end else begin
                fifo_done <= '0;
            end
            busy <= (state_next != ST_IDLE);
            if (state == ST_IDLE && grant_vld_c) begin
                active_thread <= grant_c;
            end
            if (state == ST_DONE) begin
                rr_ptr    <= active_thread;
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end

endmodule
